// File: rtl/bcd_onehot_pkg.sv
// Shared types, widths and the single-digit decode rule for the BCD one-hot bank.
package bcd_onehot_pkg;

   localparam int unsigned BCD_W    = 4;
   localparam int unsigned ONEHOT_W = 10;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   typedef struct packed {
      logic [ONEHOT_W-1:0] slice;
      logic                invalid;
   } dec_t;

   // Codes 10..15 decode to an all-zero slice with the invalid flag raised.
   function automatic dec_t decode(input logic [BCD_W-1:0] v, input logic thermo);
      dec_t r;
      r.slice   = '0;
      r.invalid = 1'b0;
      if (v > 4'd9) begin
         r.invalid = 1'b1;
      end else begin
         for (int unsigned i = 0; i < ONEHOT_W; i++) begin
            r.slice[i] = thermo ? (i <= 32'(v)) : (i == 32'(v));
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_onehot_bank_dec.sv
// Combinational single-digit BCD decoder: one-hot or thermometer slice plus invalid flag.
module bcd_digit_dec
   import bcd_onehot_pkg::*;
#(
   parameter bit THERMO = 1'b0
) (
   input  logic [BCD_W-1:0]    digit,
   output logic [ONEHOT_W-1:0] slice,
   output logic                invalid
);

   dec_t r;

   assign r       = decode(digit, THERMO);
   assign slice   = r.slice;
   assign invalid = r.invalid;

endmodule

// File: rtl/bcd_onehot_bank.sv
// Multi-digit BCD to one-hot/thermometer bank: serial MSD-first decode with
// leading-zero blanking and atomic commit under a start/busy/done handshake.
module bcd_onehot_bank
   import bcd_onehot_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit BLANK_LZ = 1'b1,
   parameter bit THERMO   = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [BCD_W*DIGITS-1:0]    bcd,
   output logic                       busy,
   output logic                       done,
   output logic [ONEHOT_W*DIGITS-1:0] onehot,
   output logic [DIGITS-1:0]          blank,
   output logic [DIGITS-1:0]          invalid
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t                      state, state_nxt;
   logic [BCD_W*DIGITS-1:0]     capture;
   logic [IDX_W-1:0]            idx;
   logic                        seen_nz;
   logic [ONEHOT_W*DIGITS-1:0]  shadow_oh, shadow_oh_nxt;
   logic [DIGITS-1:0]           shadow_bl, shadow_bl_nxt;
   logic [DIGITS-1:0]           shadow_inv, shadow_inv_nxt;
   logic [BCD_W-1:0]            dig;
   logic [ONEHOT_W-1:0]         dec_slice;
   logic                        dec_inv;
   logic                        blanked;
   logic                        accept;
   logic                        last;

   bcd_digit_dec #(.THERMO(THERMO)) u_dec (
      .digit   (dig),
      .slice   (dec_slice),
      .invalid (dec_inv)
   );

   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (state == SCAN) && (idx == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SCAN;
         SCAN:    if (idx == '0) state_nxt = DONE;
         DONE:    state_nxt = start ? SCAN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // Shadow next-value includes the digit decoded this cycle, so the final
   // SCAN edge can commit all digits at once and done lines up with the data.
   always_comb begin
      dig            = capture[int'(idx)*BCD_W +: BCD_W];
      blanked        = BLANK_LZ && (dig == '0) && !seen_nz && (idx != '0);
      shadow_oh_nxt  = shadow_oh;
      shadow_bl_nxt  = shadow_bl;
      shadow_inv_nxt = shadow_inv;
      shadow_oh_nxt[int'(idx)*ONEHOT_W +: ONEHOT_W] = blanked ? '0 : dec_slice;
      shadow_bl_nxt[idx]  = blanked;
      shadow_inv_nxt[idx] = dec_inv;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         capture    <= '0;
         idx        <= '0;
         seen_nz    <= 1'b0;
         shadow_oh  <= '0;
         shadow_bl  <= '0;
         shadow_inv <= '0;
         onehot     <= '0;
         blank      <= '0;
         invalid    <= '0;
      end else if (accept) begin
         capture <= bcd;
         idx     <= IDX_W'(DIGITS - 1);
         seen_nz <= 1'b0;
      end else if (state == SCAN) begin
         shadow_oh  <= shadow_oh_nxt;
         shadow_bl  <= shadow_bl_nxt;
         shadow_inv <= shadow_inv_nxt;
         if (dig != '0) seen_nz <= 1'b1;
         if (!last) begin
            idx <= idx - 1'b1;
         end else begin
            onehot  <= shadow_oh_nxt;
            blank   <= shadow_bl_nxt;
            invalid <= shadow_inv_nxt;
         end
      end
   end

endmodule

// File: tb/tb_bcd_onehot_bank.sv
// Scoreboard bench for bcd_onehot_bank: a default (one-hot, blanking) instance and a
// thermometer/no-blanking instance share stimulus and are checked against a reference model.
module tb_bcd_onehot_bank;

   localparam int D = 4;

   typedef struct {
      logic [10*D-1:0] oh;
      logic [D-1:0]    bl;
      logic [D-1:0]    inv;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [4*D-1:0]  bcd = '0;

   logic            busy_a, done_a, busy_b, done_b;
   logic [10*D-1:0] oh_a, oh_b;
   logic [D-1:0]    bl_a, bl_b, inv_a, inv_b;

   int checks = 0;
   int failures = 0;

   exp_t q_a[$], q_b[$];
   exp_t com_a, com_b;
   int   p = 0;

   always #5 clk = ~clk;

   bcd_onehot_bank #(.DIGITS(D), .BLANK_LZ(1'b1), .THERMO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
      .busy(busy_a), .done(done_a), .onehot(oh_a), .blank(bl_a), .invalid(inv_a)
   );

   bcd_onehot_bank #(.DIGITS(D), .BLANK_LZ(1'b0), .THERMO(1'b1)) dut_t (
      .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
      .busy(busy_b), .done(done_b), .onehot(oh_b), .blank(bl_b), .invalid(inv_b)
   );

   function automatic exp_t ref_conv(input logic [4*D-1:0] b, input bit th, input bit blz);
      exp_t e;
      bit   lead = 1'b1;
      e.oh = '0; e.bl = '0; e.inv = '0;
      for (int k = D - 1; k >= 0; k--) begin
         int unsigned v = (32'(b) >> (4 * k)) & 32'd15;
         int unsigned s;
         if (v > 9) begin
            e.inv[k] = 1'b1;
         end else if (blz && lead && v == 0 && k != 0) begin
            e.bl[k] = 1'b1;
         end else begin
            s = th ? ((32'd1 << (v + 1)) - 1) : (32'd1 << v);
            e.oh[10*k +: 10] = s[9:0];
         end
         if (v != 0) lead = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [4*D-1:0] rand_bcd();
      logic [4*D-1:0] b;
      for (int k = 0; k < D; k++) begin
         if ($urandom_range(0, 9) < 4) b[4*k +: 4] = 4'd0;
         else                          b[4*k +: 4] = 4'($urandom_range(0, 15));
      end
      return b;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
      end
   endtask

   // Reference handshake: phase 0 idle, 1..D scan, D+1 done; expectation pushed on accept.
   always @(posedge clk) begin
      if (!rst_n) begin
         p = 0;
         q_a.delete();
         q_b.delete();
         com_a = '{oh: '0, bl: '0, inv: '0};
         com_b = '{oh: '0, bl: '0, inv: '0};
      end else if ((p == 0 || p == D + 1) && start) begin
         q_a.push_back(ref_conv(bcd, 1'b0, 1'b1));
         q_b.push_back(ref_conv(bcd, 1'b1, 1'b0));
         p = 1;
      end else if (p == 0 || p == D + 1) begin
         p = 0;
      end else begin
         p++;
         if (p == D + 1 && q_a.size() > 0 && q_b.size() > 0) begin
            com_a = q_a.pop_front();
            com_b = q_b.pop_front();
         end
      end
   end

   always @(negedge clk) begin
      check("busy_a",    64'(busy_a), 64'(p != 0));
      check("done_a",    64'(done_a), 64'(p == D + 1));
      check("onehot_a",  64'(oh_a),   64'(com_a.oh));
      check("blank_a",   64'(bl_a),   64'(com_a.bl));
      check("invalid_a", 64'(inv_a),  64'(com_a.inv));
      check("busy_t",    64'(busy_b), 64'(p != 0));
      check("done_t",    64'(done_b), 64'(p == D + 1));
      check("onehot_t",  64'(oh_b),   64'(com_b.oh));
      check("blank_t",   64'(bl_b),   64'(com_b.bl));
      check("invalid_t", 64'(inv_b),  64'(com_b.inv));
   end

   task automatic pulse(input logic [4*D-1:0] b);
      @(negedge clk); #1;
      start = 1'b1;
      bcd   = b;
      @(negedge clk); #1;
      start = 1'b0;
      bcd   = rand_bcd();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      idle(3);
      #1 rst_n = 1'b1;
      idle(2);

      pulse(16'h0907); idle(D + 2);
      pulse(16'h0000); idle(D + 2);
      pulse(16'h12F3); idle(D + 2);
      pulse(16'h0003); idle(D + 2);
      pulse(16'h9000); idle(D + 2);

      // start re-asserted mid-scan with a different value must be ignored
      pulse(16'h4321);
      pulse(16'h8765);
      idle(D + 2);

      // start held high: back-to-back conversions, bcd changing every cycle
      @(negedge clk); #1;
      start = 1'b1;
      for (int i = 0; i < 3 * (D + 1); i++) begin
         bcd = rand_bcd();
         @(negedge clk); #1;
      end
      start = 1'b0;
      idle(D + 2);

      // reset two cycles into a conversion aborts it and clears outputs
      pulse(16'h5678);
      @(negedge clk); #1;
      rst_n = 1'b0;
      idle(2);
      #1 rst_n = 1'b1;
      idle(2);

      for (int i = 0; i < 40; i++) begin
         pulse(rand_bcd());
         idle($urandom_range(0, D + 3));
      end
      idle(D + 3);

      check("drain_a", 64'(q_a.size()), 64'd0);
      check("drain_t", 64'(q_b.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t got=running exp=finished", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcd_onehot_bank.md
# bcd_onehot_bank

Multi-digit, parametrised successor to the single-digit BCD-to-one-hot decoder. It converts a packed DIGITS-wide BCD value, such as the score or lives counter, into per-digit 10-bit one-hot or thermometer vectors for the HUD sprite and LED drivers. Decoding is serial, one digit per cycle, so that optional leading-zero blanking can run MSD-first. Results are committed atomically under a start/busy/done handshake. The block sits between the game score counters and the digit-glyph renderer.

## Interface
- DIGITS, 4: number of BCD digits (1..8).
- BLANK_LZ, 1: 1 blanks leading zeros; digit 0 is never blanked.
- THERMO, 0: 0 gives one-hot output; 1 gives thermometer output (value v sets bits v..0).
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion; sampled only in IDLE or DONE.
- bcd  in  4*DIGITS  packed BCD; digit k is bcd[4k+3:4k]; captured on the accepted start.
- busy  out  1  high in SCAN and DONE.
- done  out  1  one-cycle pulse; outputs are updated in that same cycle.
- onehot  out  10*DIGITS  digit k in onehot[10k+9:10k].
- blank  out  DIGITS  bit k set when digit k is a blanked leading zero.
- invalid  out  DIGITS  bit k set when digit k is a code in 10..15.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start=1 moves to SCAN. The block snapshots bcd into a capture register, sets idx to DIGITS-1 and clears seen_nz.
  - SCAN: decodes capture digit idx into a shadow register. When idx reaches 0, moves to DONE; otherwise idx decrements.
  - DONE: copies shadow to onehot, blank and invalid, and asserts done. start=1 re-captures and goes to SCAN (back-to-back conversion); otherwise goes to IDLE.
- start is ignored in SCAN. The bcd input may change freely after capture.
- Per-digit decode of value v:
  - v in 0..9: one-hot gives bit v only; thermometer gives bits v..0.
  - v in 10..15: slice is all zeros and the invalid bit is set.
- Blanking (BLANK_LZ=1):
  - A digit is blanked when v==0, seen_nz==0 and idx!=0. A blanked slice is zeros with its blank bit set.
  - Any nonzero digit sets seen_nz, including invalid codes.
- With BLANK_LZ=0, the blank output is always 0.
- Outputs hold their last committed values until the next DONE. There is no partial update during SCAN.

## Timing
- Reset: state IDLE; all outputs are 0, including busy and done. The capture, shadow, idx and seen_nz registers are cleared.
- Latency: start is sampled at edge T. busy is high from T+1. SCAN occupies T+1..T+DIGITS. done and the new outputs appear in cycle T+DIGITS+1.
- Throughput: one conversion per DIGITS+1 cycles when start is held high.
- Reset asserted mid-conversion aborts it. No done is produced and the outputs return to 0 asynchronously.
- idx width is clog2(DIGITS), minimum 1 bit. With DIGITS=1, SCAN lasts exactly one cycle.

## Structure
- Package bcd_onehot_pkg holds:
  - the state enum (IDLE/SCAN/DONE);
  - constants BCD_W=4 and ONEHOT_W=10;
  - the decode function (v, thermo) that returns a 10-bit slice plus the invalid flag.
- Sub-module bcd_digit_dec: a combinational single-digit decoder with a THERMO parameter. The top instantiates it once, muxed by idx.

## Test plan
All scenarios use DIGITS=4 and the defaults unless stated.

- **Reset:** hold rst_n=0, then release → all outputs 0 and busy=0. start at T → busy=1 at T+1, done=1 exactly at T+5.
- **Leading-zero blanking:** bcd=16'h0907 → blank=4'b1000, invalid=0. Slices: d3=0, d2=10'b1000000000, d1=10'b0000000001, d0=10'b0010000000.
- **All zeros:** bcd=16'h0000 → blank=4'b1110, d0=10'b0000000001, d3..d1=0.
- **Invalid digit:** bcd=16'h12F3 → invalid=4'b0010, d1=0, d3=10'b0000000010, d2=10'b0000000100, d0=10'b0000001000, blank=0.
- **Thermometer, no blanking:** THERMO=1, BLANK_LZ=0, bcd=16'h0003 → d0=10'b0000001111, d3..d1=10'b0000000001, blank=0.
- **Handshake:**
  - start pulsed during SCAN, with bcd changed meanwhile → ignored; the result reflects the first capture.
  - start held high → done pulses every 5 cycles.
  - rst_n dropped at T+2 → no done, and outputs become 0.
